row_open_tracker: RTL
=====================

// Module: row_open_tracker
// PURPOSE
//  Parametrised open-row tracker for the DRAM controller scheduler: one entry per (bank_group, bank).
//  Classifies each request as IDLE/HIT/MISS/CONFLICT, tracks the single in-flight activation, and closes all rows on refresh.
//  Adds an open-page idle timeout that requests auto-precharge of stale rows.
//  Sits between the request queue and the command generator; ROW_BITS and row_stat encoding come from dram_pkg.
// PARAMETERS
//  BG_COUNT      4     number of bank groups (power of 2)
//  BANK_PER_BG   4     banks per group (power of 2)
//  ROW_BITS      15    row address width (defaults to dram_pkg::ROW_BITS)
//  IDLE_TIMEOUT  64    cycles a row may stay open unreferenced before close_req; 0 = disabled
// PORTS
//  CLK             in   1                 clock, rising edge
//  nRST            in   1                 reset, asynchronous, active-low
//  req_en          in   1                 lookup request strobe
//  bank_group      in   $clog2(BG_COUNT)  target group for req_en / row_resolve
//  bank            in   $clog2(BANK_PER_BG) target bank
//  row             in   ROW_BITS          target row
//  row_resolve     in   1                 controller committed ACT (after PRE if conflict) to bank_group/bank/row
//  tACT_done       in   1                 tRCD satisfied for the in-flight activation
//  refresh         in   1                 single-cycle pulse: PREA issued, close every bank
//  close_ack       in   1                 PRE issued for the bank on close_bg/close_bank
//  row_stat        out  2                 00 IDLE/retry, 01 HIT, 10 MISS, 11 CONFLICT
//  stat_valid      out  1                 row_stat/row_conflict valid this cycle
//  row_conflict    out  ROW_BITS          open row of target bank when CONFLICT, else 0
//  all_row_closed  out  1                 no bank open and no activation in flight
//  close_req       out  1                 timed-out bank awaiting precharge
//  close_bg        out  $clog2(BG_COUNT)  group of timed-out bank
//  close_bank      out  $clog2(BANK_PER_BG) bank of timed-out bank
// BEHAVIOUR
//  Reset: all entries closed, counters 0, no pending ACT; row_stat=00, stat_valid=0, row_conflict=0,
//   all_row_closed=1, close_req=0, close_bg/close_bank=0.
//  Index idx = bank_group*BANK_PER_BG + bank. Per entry: open, open_row, idle_cnt.
//  Lookup (1-cycle latency, registered): req_en in cycle N -> stat_valid=1 in N+1 (pulse); row_stat from state at N:
//   refresh in N, or idx == pending ACT bank -> 00; closed -> 10; open & row==open_row -> 01 (clears idle_cnt);
//   open & mismatch -> 11, row_conflict=open_row. Outputs hold last value when stat_valid=0.
//  row_resolve: only when no ACT pending; latches idx/row as pending, clears entry open. row_resolve while pending: ignored.
//  tACT_done with pending: entry open, open_row=pending row, idle_cnt=0, pending cleared. Without pending: ignored.
//  row_resolve and tACT_done in the same cycle: tACT_done completes the old pending first, new resolve then latches.
//  refresh: next cycle every entry closed, pending cancelled, close_req drops; wins over same-cycle tACT_done/row_resolve/close_ack.
//  Timeout (IDLE_TIMEOUT>0): idle_cnt increments each cycle the entry is open, saturates at IDLE_TIMEOUT.
//   close_req=1 while any entry saturated; close_bg/close_bank = lowest saturated idx, stable until close_ack.
//   close_ack: that entry closed next cycle; HIT on it in the same cycle still closes it (ack wins).
//  all_row_closed registered: 1 iff no entry open and no pending ACT.
//  Reset mid-operation: immediately returns to reset state; no partial commands retained.
// STRUCTURE
//  dram_pkg: ROW_BITS, row_stat_t enum {IDLE=2'b00, HIT=2'b01, MISS=2'b10, CONFLICT=2'b11}.
//  Sub-module row_bank_entry (generated BG_COUNT*BANK_PER_BG times): open, open_row, idle_cnt, saturated flag.
//  Top: index decode, pending-ACT register, lookup output regs, lowest-index priority encoder for close_*.
//  row_open_if extended with stat_valid, close_* and close_ack.
// TESTING
//  Reset then req_en bg=1 bank=2 row=0x100 -> next cycle stat_valid=1, row_stat=10, all_row_closed=1.
//  row_resolve bg=1 bank=2 row=0x100, tACT_done 3 cycles later; req row=0x100 -> 01; req row=0x200 -> 11, row_conflict=0x100.
//  During pending ACT: req same bank -> 00; second row_resolve to bg=0 bank=0 ignored (entry stays closed).
//  Two banks open, refresh pulse with concurrent tACT_done -> next cycle all closed, all_row_closed=1, later req -> 10.
//  IDLE_TIMEOUT=8, bank 5 open, no hits -> close_req=1 with idx 5 at 8th cycle; close_ack -> bank closed; a HIT at cycle 6 restarts the count.
//  Banks 3 and 9 time out together -> close_* reports 3; after ack, reports 9.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared DRAM controller types: row address width and the lookup classification code.
package dram_pkg;
    localparam int unsigned ROW_BITS = 15;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        HIT      = 2'b01,
        MISS     = 2'b10,
        CONFLICT = 2'b11
    } row_stat_t;

    // Select-field width for n items, never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/row_open_if.sv
// Scheduler <-> open-row tracker bundle: lookup/activate/refresh in, classification and close requests out.
interface row_open_if #(
    parameter int unsigned BG_COUNT    = 4,
    parameter int unsigned BANK_PER_BG = 4,
    parameter int unsigned ROW_BITS    = dram_pkg::ROW_BITS
);
    import dram_pkg::*;

    localparam int unsigned BGW = sel_w(BG_COUNT);
    localparam int unsigned BKW = sel_w(BANK_PER_BG);

    logic                req_en;
    logic [BGW-1:0]      bank_group;
    logic [BKW-1:0]      bank;
    logic [ROW_BITS-1:0] row;
    logic                row_resolve;
    logic                tACT_done;
    logic                refresh;
    logic                close_ack;
    row_stat_t           row_stat;
    logic                stat_valid;
    logic [ROW_BITS-1:0] row_conflict;
    logic                all_row_closed;
    logic                close_req;
    logic [BGW-1:0]      close_bg;
    logic [BKW-1:0]      close_bank;

    modport master (
        output req_en, bank_group, bank, row, row_resolve, tACT_done, refresh, close_ack,
        input  row_stat, stat_valid, row_conflict, all_row_closed, close_req, close_bg, close_bank
    );

    modport slave (
        input  req_en, bank_group, bank, row, row_resolve, tACT_done, refresh, close_ack,
        output row_stat, stat_valid, row_conflict, all_row_closed, close_req, close_bg, close_bank
    );
endinterface

// File: rtl/row_open_tracker_entry.sv
// One (bank_group, bank) slot: open flag, open row and idle counter saturating at IDLE_TIMEOUT.
module row_bank_entry #(
    parameter int unsigned ROW_BITS     = 15,
    parameter int unsigned IDLE_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                close,
    input  logic                open_set,
    input  logic [ROW_BITS-1:0] open_row_in,
    input  logic                hit,
    output logic                is_open,
    output logic [ROW_BITS-1:0] open_row,
    output logic                sat
);
    localparam int unsigned CW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(IDLE_TIMEOUT);

    logic [CW-1:0] idle_cnt;

    // Close outranks open_set so a re-resolve of the just-completed bank leaves it closed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_open  <= 1'b0;
            open_row <= '0;
            idle_cnt <= '0;
        end else if (close) begin
            is_open  <= 1'b0;
            idle_cnt <= '0;
        end else if (open_set) begin
            is_open  <= 1'b1;
            open_row <= open_row_in;
            idle_cnt <= '0;
        end else if (is_open) begin
            if (hit)
                idle_cnt <= '0;
            else if (idle_cnt != LIMIT)
                idle_cnt <= idle_cnt + CW'(1);
        end
    end

    assign sat = (IDLE_TIMEOUT > 0) && is_open && (idle_cnt == LIMIT);
endmodule

// File: rtl/row_open_tracker.sv
// Open-row tracker: per-bank row state, single in-flight ACT, registered lookup and idle-close requests.
module row_open_tracker
    import dram_pkg::*;
#(
    parameter int unsigned BG_COUNT     = 4,
    parameter int unsigned BANK_PER_BG  = 4,
    parameter int unsigned ROW_BITS     = dram_pkg::ROW_BITS,
    parameter int unsigned IDLE_TIMEOUT = 64
) (
    input  logic      CLK,
    input  logic      nRST,
    row_open_if.slave bus
);
    localparam int unsigned NE   = BG_COUNT * BANK_PER_BG;
    localparam int unsigned IDXW = sel_w(NE);
    localparam int unsigned BGW  = sel_w(BG_COUNT);
    localparam int unsigned BKW  = sel_w(BANK_PER_BG);

    logic [NE-1:0]       open_vec;
    logic [NE-1:0]       sat_vec;
    logic [ROW_BITS-1:0] open_rows [NE];

    logic                pend_valid;
    logic [IDXW-1:0]     pend_idx;
    logic [ROW_BITS-1:0] pend_row;

    logic [IDXW-1:0]     req_idx;
    row_stat_t           lk_stat;
    logic [ROW_BITS-1:0] lk_conf;
    logic                lookup_hit, accept, complete, ack_fire;

    logic                any_sat, lock_valid;
    logic [IDXW-1:0]     low_idx, lock_idx, close_idx;
    logic [31:0]         close_idx32;

    assign req_idx  = IDXW'(32'(bus.bank_group) * BANK_PER_BG + 32'(bus.bank));
    assign complete = bus.tACT_done && pend_valid && !bus.refresh;
    assign accept   = bus.row_resolve && (!pend_valid || bus.tACT_done) && !bus.refresh;

    always_comb begin
        lk_stat = MISS;
        lk_conf = '0;
        if (bus.refresh || (pend_valid && pend_idx == req_idx))
            lk_stat = IDLE;
        else if (open_vec[req_idx]) begin
            if (bus.row == open_rows[req_idx])
                lk_stat = HIT;
            else begin
                lk_stat = CONFLICT;
                lk_conf = open_rows[req_idx];
            end
        end
    end

    assign lookup_hit = bus.req_en && (lk_stat == HIT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bus.stat_valid   <= 1'b0;
            bus.row_stat     <= IDLE;
            bus.row_conflict <= '0;
        end else begin
            bus.stat_valid <= bus.req_en;
            if (bus.req_en) begin
                bus.row_stat     <= lk_stat;
                bus.row_conflict <= lk_conf;
            end
        end
    end

    // A resolve in the tACT_done cycle re-arms the pending slot after the old one completes.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            pend_row   <= '0;
        end else if (bus.refresh)
            pend_valid <= 1'b0;
        else if (accept) begin
            pend_valid <= 1'b1;
            pend_idx   <= req_idx;
            pend_row   <= bus.row;
        end else if (complete)
            pend_valid <= 1'b0;
    end

    always_comb begin
        any_sat = 1'b0;
        low_idx = '0;
        for (int unsigned i = NE; i > 0; i--) begin
            if (sat_vec[i-1]) begin
                any_sat = 1'b1;
                low_idx = IDXW'(i - 1);
            end
        end
    end

    // The reported bank stays put until acked, even if a lower index saturates meanwhile.
    assign close_idx   = (lock_valid && sat_vec[lock_idx]) ? lock_idx : low_idx;
    assign ack_fire    = bus.close_ack && any_sat;
    assign close_idx32 = 32'(close_idx);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lock_valid <= 1'b0;
            lock_idx   <= '0;
        end else if (bus.refresh || ack_fire)
            lock_valid <= 1'b0;
        else if (any_sat) begin
            lock_valid <= 1'b1;
            lock_idx   <= close_idx;
        end
    end

    assign bus.close_req      = any_sat;
    assign bus.close_bg       = any_sat ? BGW'(close_idx32 / BANK_PER_BG) : '0;
    assign bus.close_bank     = any_sat ? BKW'(close_idx32 % BANK_PER_BG) : '0;
    assign bus.all_row_closed = ~|open_vec && !pend_valid;

    for (genvar g = 0; g < NE; g++) begin : g_entry
        row_bank_entry #(
            .ROW_BITS    (ROW_BITS),
            .IDLE_TIMEOUT(IDLE_TIMEOUT)
        ) u_entry (
            .clk        (CLK),
            .rst_n      (nRST),
            .close      (bus.refresh || (accept && req_idx == IDXW'(g)) ||
                         (ack_fire && close_idx == IDXW'(g))),
            .open_set   (complete && pend_idx == IDXW'(g)),
            .open_row_in(pend_row),
            .hit        (lookup_hit && req_idx == IDXW'(g)),
            .is_open    (open_vec[g]),
            .open_row   (open_rows[g]),
            .sat        (sat_vec[g])
        );
    end
endmodule
